sweep_packetizer: RTL and testbench
===================================

Name: sweep_packetizer

Overview:
- Sits directly downstream of the channel-sweep aggregator in the sys_clk domain.
- Consumes its per-channel sample stream, which is valid-only with no backpressure, and groups each sweep into a frame.
- Buffers frames in a ping-pong staging memory.
- Emits each frame as a framed packet (header, samples, trailer) on a ready/valid word stream toward the host link FIFO.

Parameters:
- NUM_CHANNELS, 16, channels per sweep; max samples per frame.
- DATA_WIDTH, 16, sample width; must be <= 16.
- CH_ID_WIDTH, 4, channel-id width; must be <= 8 and able to hold NUM_CHANNELS-1.
- GAP_CYCLES, 20, idle cycles after last sample that close an open frame; must be > NUM_CHANNELS.

Ports:
- sys_clk, input, 1, sole clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_data, input, DATA_WIDTH, sample value.
- in_channel, input, CH_ID_WIDTH, sample channel id.
- in_valid, input, 1, sample strobe; no backpressure, may be high every cycle.
- out_data, output, 32, packet word.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, consumer accepts word when out_valid && out_ready.
- out_last, output, 1, high on trailer word.
- frame_drop_count, output, 16, saturating count of dropped frames.
- busy, output, 1, high while any frame is open, staged or being serialized.

Behaviour:
- Reset values: out_valid=0, out_last=0, out_data=0, frame_drop_count=0, busy=0. Both banks free and bitmaps cleared. seq=0. No frame open.
- Sample acceptance: a sample is accepted when in_valid=1 and in_channel < NUM_CHANNELS. Samples with in_channel >= NUM_CHANNELS are ignored entirely and do not reset the gap counter.
- Frame open: an accepted sample with no frame open claims the lowest-index free bank (bank 0 before bank 1). If neither bank is free, the frame enters DROP.
- Frame store: the sample is written to bank[in_channel] and its valid-bitmap bit is set. last_ch records in_channel.
- Frame close, any of:
  - (a) Accepted sample with in_channel <= last_ch: the current frame closes and this sample opens the next frame in the same cycle.
  - (b) Accepted sample with in_channel == NUM_CHANNELS-1: close after storing it.
  - (c) Gap counter reaches GAP_CYCLES: close on that cycle. The counter clears on every accepted sample.
- Closed banks are queued for serialization in close order (2-deep).
- DROP state: samples are discarded until the frame closes by the same rules. frame_drop_count increments by 1 at close and saturates at 16'hFFFF. seq is not advanced. busy stays high.
- Serializer FSM states: IDLE, HDR, BODY, TRL.
  - IDLE -> HDR when the queue is non-empty. The header is presented the cycle after close if the serializer was idle.
  - HDR -> BODY on handshake.
  - BODY walks channel index 0..NUM_CHANNELS-1 in ascending order. It presents a word for each set bitmap bit and skips clear bits at one index per cycle; out_valid may be low during skips. BODY -> TRL after the highest set bit is accepted.
  - TRL -> IDLE on handshake. This frees the bank, clears its bitmap and increments seq (8-bit wrap).
- Word formats:
  - Header: [31:24]=8'hA5, [23:16]=seq, [15:8]=sample count, [7:0]=0.
  - Sample: [31:24]=8'h5C, [23:16]=channel zero-extended, [15:0]=data zero-extended.
  - Trailer: [31:24]=8'h5A, [23:16]=seq, [15:0]=XOR of all zero-extended sample data in the packet. out_last=1 on trailer only.
- Handshake: out_data and out_last hold stable while out_valid && !out_ready. out_valid never drops without a handshake once asserted.
- Simultaneous close of frame A and serializer completing bank B in one cycle: the freed bank is available for a frame opening in the same cycle.
- Reset mid-operation: the open frame, staged banks and the in-flight packet are discarded without a trailer. All state returns to reset values.

Test Plan:
- Single sweep: mask all-ones, channels 0..15 back-to-back, data=ch*0x11, out_ready=1 -> header A5_00_10_00, 16 samples in order, trailer 5A_00_0000 (XOR of 0x00..0xFF step 0x11 = 0x0000), out_last on word 18.
- Sparse sweep: channels 2,5,9 with data 0x1234, 0x00FF, 0x8000, then 25 idle cycles -> close at 20th idle cycle; header count=3, samples in order, trailer checksum 0x92CB.
- Back-to-back frames: sweep 0..7 immediately followed by channel 0 -> first frame closes via rule (a); two packets with seq 0 then 1, no samples lost.
- Backpressure/drop: out_ready=0 while three full sweeps arrive -> first two staged, third dropped, frame_drop_count=1. Release out_ready -> exactly two packets (seq 0,1), out_data stable during stall.
- Out-of-range/illegal input: in_channel=15 with NUM_CHANNELS=12 -> ignored, no frame opened, busy stays 0.
- Reset mid-packet: assert rst_n low during BODY -> all outputs zero next cycle. A subsequent sweep produces a packet with seq=0.

Source files
------------

// File: rtl/sweep_packetizer.sv
// sweep_packetizer: groups per-channel sweep samples into frames held in two
// staging banks, then serializes each as header / samples / trailer words.
// Ports: sys_clk, rst_n (async, active low); in_data/in_channel/in_valid
// sample stream (no backpressure); out_data/out_valid/out_ready/out_last
// packet word stream; frame_drop_count (saturating); busy.
module sweep_packetizer #(
    parameter int NUM_CHANNELS = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int CH_ID_WIDTH  = 4,
    parameter int GAP_CYCLES   = 20
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [CH_ID_WIDTH-1:0] in_channel,
    input  logic                   in_valid,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [15:0]            frame_drop_count,
    output logic                   busy
);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_TRL} state_t;

    state_t                  state_q, state_d;
    logic [NUM_CHANNELS-1:0] bmp_q [2];
    logic [NUM_CHANNELS-1:0] bmp_d [2];
    logic [1:0]              used_q, used_d;
    logic                    open_q, open_d;
    logic                    drop_q, drop_d;
    logic                    cur_q, cur_d;
    logic [CH_ID_WIDTH-1:0]  last_ch_q, last_ch_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic                    qb0_q, qb0_d;
    logic                    qb1_q, qb1_d;
    logic [1:0]              qcnt_q, qcnt_d;
    logic [CH_ID_WIDTH-1:0]  idx_q, idx_d;
    logic [7:0]              seq_q, seq_d;
    logic [15:0]             csum_q, csum_d;
    logic [15:0]             drops_q, drops_d;
    logic [DATA_WIDTH-1:0]   mem_q [2][NUM_CHANNELS];

    logic                    head;
    logic [NUM_CHANNELS-1:0] hbmp;
    logic [7:0]              hcnt;
    logic                    more;
    logic                    cur_bit;
    logic [DATA_WIDTH-1:0]   cur_dat;
    logic                    hs;
    logic                    release_b;
    logic                    acc;
    logic                    enq, enq_b;
    logic                    wr_en, wr_b;
    logic                    nb, ndrop;
    logic                    close_now, close_b, close_drop;

    // Head of the close-order queue is the bank being serialized.
    assign head    = qb0_q;
    assign hbmp    = bmp_q[head];
    assign cur_bit = hbmp[idx_q];
    assign cur_dat = mem_q[head][idx_q];
    assign acc     = in_valid && (32'(in_channel) < NUM_CHANNELS);

    always_comb begin
        hcnt = '0;
        more = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            hcnt = hcnt + 8'(hbmp[i]);
            if (i > int'(idx_q) && hbmp[i]) more = 1'b1;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        unique case (state_q)
            S_HDR: begin
                out_valid = 1'b1;
                out_data  = {8'hA5, seq_q, hcnt, 8'h00};
            end
            S_BODY: begin
                out_valid = cur_bit;
                out_data  = {8'h5C, 8'(idx_q), 16'(cur_dat)};
            end
            S_TRL: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = {8'h5A, seq_q, csum_q};
            end
            default: ;
        endcase
    end

    assign hs        = out_valid && out_ready;
    assign release_b = (state_q == S_TRL) && out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        csum_d  = csum_q;
        unique case (state_q)
            S_IDLE: if (qcnt_q != 2'd0 || enq) state_d = S_HDR;
            S_HDR: if (hs) begin
                state_d = S_BODY;
                idx_d   = '0;
                csum_d  = '0;
            end
            S_BODY: begin
                if (!cur_bit) begin
                    idx_d = idx_q + 1'b1;
                end else if (hs) begin
                    csum_d = csum_q ^ 16'(cur_dat);
                    if (more) idx_d = idx_q + 1'b1;
                    else state_d = S_TRL;
                end
            end
            S_TRL: if (hs) begin
                state_d = S_IDLE;
                seq_d   = seq_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        used_d     = used_q;
        open_d     = open_q;
        drop_d     = drop_q;
        cur_d      = cur_q;
        last_ch_d  = last_ch_q;
        gap_d      = gap_q;
        drops_d    = drops_q;
        bmp_d      = bmp_q;
        qcnt_d     = qcnt_q;
        qb0_d      = qb0_q;
        qb1_d      = qb1_q;
        enq        = 1'b0;
        enq_b      = cur_q;
        wr_en      = 1'b0;
        wr_b       = cur_q;
        nb         = cur_q;
        ndrop      = drop_q;
        close_now  = 1'b0;
        close_b    = cur_q;
        close_drop = drop_q;

        // A bank finishing its trailer is free for a frame opening now.
        if (release_b) begin
            used_d[head] = 1'b0;
            bmp_d[head]  = '0;
        end

        if (acc) begin
            gap_d = '0;
            if (open_q && in_channel <= last_ch_q) close_now = 1'b1;
            if (!open_q || close_now) begin
                if (!used_d[0]) nb = 1'b0;
                else if (!used_d[1]) nb = 1'b1;
                else ndrop = 1'b1;
                if (!used_d[0] || !used_d[1]) ndrop = 1'b0;
                if (!ndrop) used_d[nb] = 1'b1;
                open_d = 1'b1;
                drop_d = ndrop;
                cur_d  = nb;
            end
            if (!ndrop) begin
                wr_en = 1'b1;
                wr_b  = nb;
                bmp_d[nb][in_channel] = 1'b1;
            end
            last_ch_d = in_channel;
            if (in_channel == CH_ID_WIDTH'(NUM_CHANNELS - 1)) begin
                close_now  = 1'b1;
                close_b    = nb;
                close_drop = ndrop;
                open_d     = 1'b0;
            end
        end else if (open_q) begin
            if (gap_q == GW'(GAP_CYCLES - 1)) begin
                close_now = 1'b1;
                open_d    = 1'b0;
                gap_d     = '0;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end

        if (close_now) begin
            if (close_drop) begin
                if (drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
            end else begin
                enq   = 1'b1;
                enq_b = close_b;
            end
        end

        if (release_b) begin
            qb0_d  = qb1_q;
            qcnt_d = qcnt_q - 2'd1;
        end
        if (enq) begin
            if (qcnt_d == 2'd0) qb0_d = enq_b;
            else qb1_d = enq_b;
            qcnt_d = qcnt_d + 2'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bmp_q[0]  <= '0;
            bmp_q[1]  <= '0;
            used_q    <= '0;
            open_q    <= 1'b0;
            drop_q    <= 1'b0;
            cur_q     <= 1'b0;
            last_ch_q <= '0;
            gap_q     <= '0;
            qb0_q     <= 1'b0;
            qb1_q     <= 1'b0;
            qcnt_q    <= '0;
            idx_q     <= '0;
            seq_q     <= '0;
            csum_q    <= '0;
            drops_q   <= '0;
        end else begin
            state_q   <= state_d;
            bmp_q     <= bmp_d;
            used_q    <= used_d;
            open_q    <= open_d;
            drop_q    <= drop_d;
            cur_q     <= cur_d;
            last_ch_q <= last_ch_d;
            gap_q     <= gap_d;
            qb0_q     <= qb0_d;
            qb1_q     <= qb1_d;
            qcnt_q    <= qcnt_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
            csum_q    <= csum_d;
            drops_q   <= drops_d;
        end
    end

    // Sample storage; validity is tracked by the bitmaps, so no reset.
    always_ff @(posedge sys_clk) begin
        if (wr_en) mem_q[wr_b][in_channel] <= in_data;
    end

    assign frame_drop_count = drops_q;
    assign busy             = open_q || (qcnt_q != 2'd0);

endmodule

// File: tb/tb_sweep_packetizer.sv
// tb_sweep_packetizer: directed table-driven bench for sweep_packetizer.
// A second instance with 12 channels covers out-of-range channel ids.
module tb_sweep_packetizer;

    typedef struct packed {
        logic [3:0]  ch;
        logic [15:0] data;
        logic [31:0] exp;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic [3:0]  in_channel;
    logic        in_valid;
    logic        in_valid12;
    logic [31:0] out_data, out_data12;
    logic        out_valid, out_valid12;
    logic        out_ready, out_ready12;
    logic        out_last, out_last12;
    logic [15:0] frame_drop_count, frame_drop_count12;
    logic        busy, busy12;

    always #5 sys_clk = ~sys_clk;

    sweep_packetizer u_dut (
        .sys_clk          (sys_clk),
        .rst_n            (rst_n),
        .in_data          (in_data),
        .in_channel       (in_channel),
        .in_valid         (in_valid),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last),
        .frame_drop_count (frame_drop_count),
        .busy             (busy)
    );

    sweep_packetizer #(.NUM_CHANNELS(12)) u_dut12 (
        .sys_clk          (sys_clk),
        .rst_n            (rst_n),
        .in_data          (in_data),
        .in_channel       (in_channel),
        .in_valid         (in_valid12),
        .out_data         (out_data12),
        .out_valid        (out_valid12),
        .out_ready        (out_ready12),
        .out_last         (out_last12),
        .frame_drop_count (frame_drop_count12),
        .busy             (busy12)
    );

    logic [32:0] cap[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_seq = 0;
    vec_t        fa[16];
    vec_t        fb[16];
    vec_t        fc[16];

    always @(negedge sys_clk)
        if (rst_n && out_valid && out_ready)
            cap.push_back({out_last, out_data});

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic put(input logic [3:0] ch, input logic [15:0] d);
        in_valid   = 1'b1;
        in_channel = ch;
        in_data    = d;
        tick(1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        tick(n);
    endtask

    task automatic send(input vec_t f[16], input int n);
        for (int i = 0; i < n; i++) put(f[i].ch, f[i].data);
    endtask

    task automatic wait_words(input string nm, input int n);
        int budget;
        budget = 300;
        while (cap.size() < n && budget > 0) begin
            tick(1);
            budget--;
        end
        chk({nm, "_wait"}, 64'(cap.size() >= n), 64'd1);
    endtask

    function automatic logic [15:0] xsum(input vec_t f[16], input int n);
        logic [15:0] x;
        x = '0;
        for (int i = 0; i < n; i++) x = x ^ f[i].data;
        return x;
    endfunction

    task automatic pkt_check(input string nm, input vec_t f[16],
                             input int n, input logic [15:0] cs);
        logic [32:0] w;
        w = (cap.size() > 0) ? cap.pop_front() : 'x;
        chk({nm, "_hdr"}, 64'(w),
            64'({1'b0, 8'hA5, 8'(exp_seq), 8'(n), 8'h00}));
        for (int i = 0; i < n; i++) begin
            w = (cap.size() > 0) ? cap.pop_front() : 'x;
            chk($sformatf("%s_s%0d", nm, i), 64'(w), 64'({1'b0, f[i].exp}));
        end
        w = (cap.size() > 0) ? cap.pop_front() : 'x;
        chk({nm, "_trl"}, 64'(w), 64'({1'b1, 8'h5A, 8'(exp_seq), cs}));
        exp_seq++;
    endtask

    task automatic fill(output vec_t f[16], input logic [15:0] base,
                        input logic [15:0] step);
        for (int i = 0; i < 16; i++) begin
            f[i].ch   = 4'(i);
            f[i].data = base + 16'(i) * step;
            f[i].exp  = {8'h5C, 8'(i), base + 16'(i) * step};
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_valid12  = 1'b0;
        in_channel  = '0;
        in_data     = '0;
        out_ready   = 1'b1;
        out_ready12 = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_drops", frame_drop_count, 0);
        chk("rst_busy", busy, 0);

        // Full sweep, checksum of ch*0x11 over 0..15 is zero.
        fill(fa, 16'h0000, 16'h0011);
        send(fa, 16);
        idle(1);
        wait_words("single", 18);
        pkt_check("single", fa, 16, 16'h0000);
        tick(2);
        chk("single_busy_end", busy, 0);

        // Sparse sweep closed by the idle gap.
        fb[0] = '{ch: 4'd2, data: 16'h1234, exp: 32'h5C02_1234};
        fb[1] = '{ch: 4'd5, data: 16'h00FF, exp: 32'h5C05_00FF};
        fb[2] = '{ch: 4'd9, data: 16'h8000, exp: 32'h5C09_8000};
        send(fb, 3);
        idle(19);
        chk("gap_early", out_valid, 0);
        chk("gap_busy", busy, 1);
        idle(1);
        chk("gap_close_valid", out_valid, 1);
        chk("gap_close_hdr", out_data, 32'hA501_0300);
        idle(5);
        wait_words("sparse", 5);
        pkt_check("sparse", fb, 3, 16'h92CB);

        // Channel wrap closes the first frame and opens the second.
        fill(fa, 16'h0100, 16'h0003);
        fill(fb, 16'hBEE0, 16'h0001);
        send(fa, 8);
        send(fb, 4);
        idle(25);
        wait_words("b2b", 16);
        pkt_check("b2b_a", fa, 8, xsum(fa, 8));
        pkt_check("b2b_b", fb, 4, xsum(fb, 4));

        // Stalled consumer: two staged, third dropped.
        out_ready = 1'b0;
        fill(fa, 16'h1000, 16'h0001);
        fill(fb, 16'h2000, 16'h0101);
        fill(fc, 16'hF000, 16'h0001);
        send(fa, 16);
        send(fb, 16);
        send(fc, 16);
        idle(1);
        chk("drop_count", frame_drop_count, 1);
        chk("drop_busy", busy, 1);
        chk("stall_valid", out_valid, 1);
        chk("stall_hdr0", out_data, {8'hA5, 8'(exp_seq), 16'h1000});
        tick(1);
        chk("stall_hdr1", out_data, {8'hA5, 8'(exp_seq), 16'h1000});
        chk("stall_last", out_last, 0);
        out_ready = 1'b1;
        wait_words("stall", 36);
        pkt_check("stall_a", fa, 16, xsum(fa, 16));
        pkt_check("stall_b", fb, 16, xsum(fb, 16));
        idle(40);
        chk("stall_no_third", 64'(cap.size()), 0);
        chk("stall_busy_end", busy, 0);

        // Out-of-range channels on the 12-channel instance.
        in_valid12 = 1'b1;
        in_channel = 4'd15;
        in_data    = 16'h0001;
        tick(1);
        in_channel = 4'd12;
        tick(1);
        in_valid12 = 1'b0;
        tick(1);
        chk("oor_busy", busy12, 0);
        chk("oor_valid", out_valid12, 0);
        in_valid12 = 1'b1;
        in_channel = 4'd11;
        in_data    = 16'hABCD;
        tick(1);
        in_valid12 = 1'b0;
        chk("top_ch_busy", busy12, 1);
        chk("top_ch_hdr", out_data12, 32'hA500_0100);
        tick(6);

        // Reset while the body is streaming.
        fill(fa, 16'h3000, 16'h0001);
        send(fa, 16);
        idle(1);
        begin
            int budget;
            budget = 50;
            while (cap.size() < 5 && budget > 0) begin
                tick(1);
                budget--;
            end
        end
        chk("mid_reached_body", 64'(cap.size() >= 5), 1);
        #1;
        rst_n = 1'b0;
        @(negedge sys_clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_drops", frame_drop_count, 0);
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        cap.delete();
        exp_seq = 0;
        tick(1);
        fill(fb, 16'h4000, 16'h0010);
        send(fb, 16);
        idle(1);
        wait_words("post_rst", 18);
        pkt_check("post_rst", fb, 16, xsum(fb, 16));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
